// File: rtl/axis_trigger_burst_sched.sv
// rtl/axis_trigger_burst_sched.sv - software-armed trigger-gated DMA-to-DAC burst sequencer (optional macro: AXIS_TRIG_SCHED_TIMEOUT_EN)
module axis_trigger_burst_sched #(
    parameter int DATA_WIDTH      = 16,
    parameter int TRIG_DATA_WIDTH = 16,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int CNT_WIDTH       = 32,
    parameter int BURST_WIDTH     = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       cfg_start,
    input  logic                       cfg_abort,
    input  logic [BURST_WIDTH-1:0]     cfg_num_bursts,
    input  logic [SAMPLE_WIDTH-1:0]    cfg_threshold,
    input  logic [CNT_WIDTH-1:0]       cfg_delay,
    input  logic [CNT_WIDTH-1:0]       cfg_holdoff,
    input  logic [CNT_WIDTH-1:0]       cfg_timeout,
    input  logic [DATA_WIDTH-1:0]      s_data_tdata,
    input  logic                       s_data_tvalid,
    input  logic                       s_data_tlast,
    output logic                       s_data_tready,
    output logic [DATA_WIDTH-1:0]      m_data_tdata,
    output logic                       m_data_tvalid,
    output logic                       m_data_tlast,
    input  logic                       m_data_tready,
    input  logic [TRIG_DATA_WIDTH-1:0] s_trig_tdata,
    input  logic                       s_trig_tvalid,
    output logic                       s_trig_tready,
    output logic                       sts_busy,
    output logic                       sts_done,
    output logic [2:0]                 sts_state,
    output logic [BURST_WIDTH-1:0]     sts_burst_cnt,
    output logic                       sts_timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = 1;
    localparam logic [BURST_WIDTH-1:0] BURST_ONE = 1;

    logic [2:0]                     state_q;
    logic [2:0]                     state_next;
    logic [BURST_WIDTH-1:0]         num_q;
    logic [BURST_WIDTH-1:0]         burst_cnt_q;
    logic [BURST_WIDTH-1:0]         burst_inc;
    logic signed [SAMPLE_WIDTH-1:0] thr_q;
    logic signed [SAMPLE_WIDTH-1:0] prev_q;
    logic signed [SAMPLE_WIDTH-1:0] cur;
    logic [CNT_WIDTH-1:0]           delay_q;
    logic [CNT_WIDTH-1:0]           holdoff_q;
    logic [CNT_WIDTH-1:0]           cnt_q;
    logic                           prev_valid_q;
    logic                           abort_pending_q;
    logic                           done_q;

    logic start_ok;
    logic fire;
    logic tlast_hs;
    logic last_burst;
    logic enter_wait;
    logic timeout_hit;
    logic timeout_flag;
    logic unused_ok;

    // abort beats start when both arrive in the same IDLE cycle
    assign start_ok   = (state_q == S_IDLE) && cfg_start && !cfg_abort;
    assign cur        = s_trig_tdata[SAMPLE_WIDTH-1:0];
    // the first beat after WAIT_TRIG entry only primes prev, so a held level never fires
    assign fire       = (state_q == S_WAIT) && s_trig_tvalid && prev_valid_q &&
                        (prev_q <= thr_q) && (cur > thr_q);
    assign tlast_hs   = (state_q == S_RUN) && s_data_tvalid && m_data_tready && s_data_tlast;
    assign burst_inc  = burst_cnt_q + BURST_ONE;
    assign last_burst = (burst_inc == num_q);
    assign enter_wait = (state_next == S_WAIT) && (state_q != S_WAIT);

`ifdef AXIS_TRIG_SCHED_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] timeout_q;
    logic [CNT_WIDTH-1:0] to_cnt_q;
    logic                 timeout_flag_q;

    assign timeout_hit  = (state_q == S_WAIT) && (timeout_q != '0) && (to_cnt_q == timeout_q - CNT_ONE);
    assign timeout_flag = timeout_flag_q;
    assign unused_ok    = ^s_trig_tdata;

    // WAIT_TRIG watchdog: restarts on every entry, saturates, sticky flag cleared by an accepted start
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            timeout_q      <= '0;
            to_cnt_q       <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            if (start_ok) begin
                timeout_q <= cfg_timeout;
            end
            if (enter_wait) begin
                to_cnt_q <= '0;
            end else if ((state_q == S_WAIT) && (to_cnt_q != '1)) begin
                to_cnt_q <= to_cnt_q + CNT_ONE;
            end
            if (start_ok) begin
                timeout_flag_q <= 1'b0;
            end else if (timeout_hit && !cfg_abort && !fire) begin
                timeout_flag_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
    assign unused_ok    = ^{s_trig_tdata, cfg_timeout};
`endif

    // state register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // next-state logic; packets in RUN are never cut short, abort is only honoured at TLAST
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok && (cfg_num_bursts != '0)) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cfg_abort) begin
                    state_next = S_IDLE;
                end else if (fire) begin
                    state_next = (delay_q != '0) ? S_DELAY : S_RUN;
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_DELAY: begin
                if (cfg_abort) begin
                    state_next = S_IDLE;
                end else if (cnt_q == delay_q - CNT_ONE) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (tlast_hs) begin
                    if (last_burst || abort_pending_q || cfg_abort) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = (holdoff_q != '0) ? S_HOLD : S_WAIT;
                    end
                end
            end
            S_HOLD: begin
                if (cfg_abort) begin
                    state_next = S_IDLE;
                end else if (cnt_q == holdoff_q - CNT_ONE) begin
                    state_next = S_WAIT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // config latch, burst/phase counters, abort and trigger history
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            num_q           <= '0;
            thr_q           <= '0;
            delay_q         <= '0;
            holdoff_q       <= '0;
            burst_cnt_q     <= '0;
            cnt_q           <= '0;
            prev_q          <= '0;
            prev_valid_q    <= 1'b0;
            abort_pending_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q <= (start_ok && (cfg_num_bursts == '0)) || (tlast_hs && last_burst);
            if (start_ok) begin
                num_q       <= cfg_num_bursts;
                thr_q       <= cfg_threshold;
                delay_q     <= cfg_delay;
                holdoff_q   <= cfg_holdoff;
                burst_cnt_q <= '0;
            end else if (tlast_hs) begin
                burst_cnt_q <= burst_inc;
            end
            if (state_next != state_q) begin
                cnt_q <= '0;
            end else if ((state_q == S_DELAY) || (state_q == S_HOLD)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (state_next == S_IDLE) begin
                abort_pending_q <= 1'b0;
            end else if ((state_q == S_RUN) && cfg_abort) begin
                abort_pending_q <= 1'b1;
            end
            if (s_trig_tvalid) begin
                prev_q <= cur;
            end
            if (enter_wait) begin
                prev_valid_q <= 1'b0;
            end else if (s_trig_tvalid) begin
                prev_valid_q <= 1'b1;
            end
        end
    end

    // outputs: zero-latency pass-through only while in RUN, everything else forced low
    always_comb begin
        s_trig_tready = 1'b1;
        sts_busy      = (state_q != S_IDLE);
        sts_done      = done_q;
        sts_state     = state_q;
        sts_burst_cnt = burst_cnt_q;
        sts_timeout   = timeout_flag;
        s_data_tready = 1'b0;
        m_data_tvalid = 1'b0;
        m_data_tdata  = '0;
        m_data_tlast  = 1'b0;
        if (state_q == S_RUN) begin
            s_data_tready = m_data_tready;
            m_data_tvalid = s_data_tvalid;
            m_data_tdata  = s_data_tdata;
            m_data_tlast  = s_data_tlast;
        end
    end

endmodule

// File: tb/tb_axis_trigger_burst_sched.sv
// tb/tb_axis_trigger_burst_sched.sv - directed self-checking bench for axis_trigger_burst_sched
module tb_axis_trigger_burst_sched;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [15:0] cfg_num_bursts = '0;
    logic [15:0] cfg_threshold = '0;
    logic [31:0] cfg_delay = '0;
    logic [31:0] cfg_holdoff = '0;
    logic [31:0] cfg_timeout = '0;
    logic [15:0] s_data_tdata = '0;
    logic        s_data_tvalid = 1'b0;
    logic        s_data_tlast = 1'b0;
    logic        s_data_tready;
    logic [15:0] m_data_tdata;
    logic        m_data_tvalid;
    logic        m_data_tlast;
    logic        m_data_tready = 1'b1;
    logic [15:0] s_trig_tdata = '0;
    logic        s_trig_tvalid = 1'b0;
    logic        s_trig_tready;
    logic        sts_busy;
    logic        sts_done;
    logic [2:0]  sts_state;
    logic [15:0] sts_burst_cnt;
    logic        sts_timeout;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit pk_done = 0;
    logic [16:0] mon_q[$];
    int          mon_cyc[$];
    logic [15:0] bc_q[$];
    logic [15:0] last_bc = '0;

    axis_trigger_burst_sched dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_num_bursts(cfg_num_bursts),
        .cfg_threshold(cfg_threshold), .cfg_delay(cfg_delay), .cfg_holdoff(cfg_holdoff),
        .cfg_timeout(cfg_timeout),
        .s_data_tdata(s_data_tdata), .s_data_tvalid(s_data_tvalid), .s_data_tlast(s_data_tlast),
        .s_data_tready(s_data_tready),
        .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid), .m_data_tlast(m_data_tlast),
        .m_data_tready(m_data_tready),
        .s_trig_tdata(s_trig_tdata), .s_trig_tvalid(s_trig_tvalid), .s_trig_tready(s_trig_tready),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_state(sts_state),
        .sts_burst_cnt(sts_burst_cnt), .sts_timeout(sts_timeout)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // DAC-side monitor sampled mid-cycle
    always @(negedge aclk) begin
        if (m_data_tvalid && m_data_tready) begin
            mon_q.push_back({m_data_tlast, m_data_tdata});
            mon_cyc.push_back(cyc);
        end
        if (sts_done) done_cnt++;
        if (sts_burst_cnt != last_bc) begin
            if (sts_burst_cnt != 16'd0) bc_q.push_back(sts_burst_cnt);
            last_bc = sts_burst_cnt;
        end
    end

    task automatic tick();
        @(posedge aclk); #1;
    endtask

    task automatic clear();
        mon_q.delete(); mon_cyc.delete(); bc_q.delete(); done_cnt = 0;
    endtask

    task automatic arm(input logic [15:0] num, input logic [15:0] thr, input logic [31:0] dly,
                       input logic [31:0] hold, input logic [31:0] tmo);
        cfg_num_bursts = num; cfg_threshold = thr; cfg_delay = dly; cfg_holdoff = hold; cfg_timeout = tmo;
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    endtask

    task automatic send_trig(input logic [15:0] v);
        s_trig_tvalid = 1'b1; s_trig_tdata = v; tick(); s_trig_tvalid = 1'b0;
    endtask

    task automatic send_packet(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            bit ok;
            int g;
            s_data_tvalid = 1'b1; s_data_tdata = 16'(base + i); s_data_tlast = (i == n - 1);
            ok = 0; g = 0;
            while (!ok && g < 400) begin
                @(negedge aclk); ok = s_data_tready; @(posedge aclk); #1; g++;
            end
        end
        s_data_tvalid = 1'b0; s_data_tlast = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; s_data_tvalid = 1'b1; s_data_tdata = 16'hBEEF;
        tick(); tick();
        tests++; if (sts_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", sts_state); end
        tests++; if (sts_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", sts_busy); end
        tests++; if (sts_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", sts_done); end
        tests++; if (sts_burst_cnt !== 16'd0) begin fails++; $display("FAIL reset_burst_cnt: got %0d want 0", sts_burst_cnt); end
        tests++; if (sts_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", sts_timeout); end
        tests++; if (m_data_tvalid !== 1'b0 || m_data_tdata !== 16'd0) begin fails++; $display("FAIL reset_gate: got tvalid=%b tdata=%h want 0/0000", m_data_tvalid, m_data_tdata); end
        tests++; if (s_data_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready: got %b want 0", s_data_tready); end
        tests++; if (s_trig_tready !== 1'b1) begin fails++; $display("FAIL trig_tready: got %b want 1", s_trig_tready); end
        aresetn = 1'b1; s_data_tvalid = 1'b0; s_data_tdata = '0;
        tick();
    endtask

    task automatic test_single_burst();
        int t_trig;
        logic [16:0] exp;
        clear();
        arm(16'd1, 16'd5000, 32'd0, 32'd0, 32'd0);
        tests++; if (sts_state !== 3'd1) begin fails++; $display("FAIL single_armed: got state %0d want 1", sts_state); end
        fork
            begin
                send_trig(16'd100); send_trig(16'd4000); t_trig = cyc; send_trig(16'd6000);
                tests++; if (sts_state !== 3'd3) begin fails++; $display("FAIL single_run_entry: got state %0d want 3", sts_state); end
            end
            send_packet(4, 16'h1000);
        join
        tick(); tick();
        tests++; if (mon_q.size() !== 4) begin fails++; $display("FAIL single_beats: got %0d want 4", mon_q.size()); end
        for (int i = 0; i < 4; i++) begin
            exp = {1'(i == 3), 16'(16'h1000 + i)};
            tests++; if (i >= mon_q.size() || mon_q[i] !== exp) begin fails++; $display("FAIL single_beat%0d: got %h want %h", i, (i < mon_q.size()) ? mon_q[i] : 17'h0, exp); end
        end
        tests++; if (mon_cyc.size() < 1 || mon_cyc[0] - t_trig !== 1) begin fails++; $display("FAIL single_latency: got %0d want 1", (mon_cyc.size() > 0) ? mon_cyc[0] - t_trig : -1); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL single_done: got %0d pulses want 1", done_cnt); end
        tests++; if (sts_burst_cnt !== 16'd1) begin fails++; $display("FAIL single_burst_cnt: got %0d want 1", sts_burst_cnt); end
        tests++; if (sts_state !== 3'd0) begin fails++; $display("FAIL single_idle: got state %0d want 0", sts_state); end
    endtask

    task automatic test_level_no_crossing();
        clear();
        s_trig_tvalid = 1'b1; s_trig_tdata = 16'd100;
        tick(); tick();
        arm(16'd1, 16'd5000, 32'd0, 32'd0, 32'd0);
        s_trig_tdata = 16'd6000;
        repeat (5) tick();
        tests++; if (sts_state !== 3'd1) begin fails++; $display("FAIL level_no_fire: got state %0d want 1", sts_state); end
        s_data_tvalid = 1'b1; s_data_tdata = 16'h7777; #1;
        tests++; if (m_data_tvalid !== 1'b0 || s_data_tready !== 1'b0) begin fails++; $display("FAIL wait_gate: got m_tvalid=%b s_tready=%b want 0/0", m_data_tvalid, s_data_tready); end
        s_data_tvalid = 1'b0;
        s_trig_tdata = 16'd100; tick();
        s_trig_tdata = 16'd6000; tick();
        s_trig_tvalid = 1'b0;
        tests++; if (sts_state !== 3'd3) begin fails++; $display("FAIL level_cross_fire: got state %0d want 3", sts_state); end
        send_packet(1, 16'h2000);
        tick(); tick();
        tests++; if (mon_q.size() !== 1 || done_cnt !== 1) begin fails++; $display("FAIL level_packet: got beats=%0d done=%0d want 1/1", mon_q.size(), done_cnt); end
    endtask

    task automatic test_delay_holdoff();
        int t_trig[3];
        int t_wait[3];
        logic [16:0] exp;
        clear();
        arm(16'd3, 16'd5000, 32'd10, 32'd20, 32'd0);
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    int g;
                    if (k > 0) begin
                        g = 0; while (sts_state !== 3'd4 && g < 200) begin tick(); g++; end
                        send_trig(16'd100); send_trig(16'd6000);
                        tests++; if (sts_state !== 3'd4) begin fails++; $display("FAIL holdoff_ignore%0d: got state %0d want 4", k, sts_state); end
                        g = 0; while (sts_state !== 3'd1 && g < 200) begin tick(); g++; end
                        t_wait[k] = cyc;
                    end
                    send_trig(16'd100); t_trig[k] = cyc; send_trig(16'd6000);
                end
            end
            for (int k = 0; k < 3; k++) send_packet(3, 16'(16'h3000 + 16 * k));
        join
        tick(); tick();
        tests++; if (mon_q.size() !== 9) begin fails++; $display("FAIL dh_beats: got %0d want 9", mon_q.size()); end
        for (int j = 0; j < 9; j++) begin
            exp = {1'(j % 3 == 2), 16'(16'h3000 + 16 * (j / 3) + (j % 3))};
            tests++; if (j >= mon_q.size() || mon_q[j] !== exp) begin fails++; $display("FAIL dh_beat%0d: got %h want %h", j, (j < mon_q.size()) ? mon_q[j] : 17'h0, exp); end
        end
        for (int k = 0; k < 3; k++) begin
            tests++; if (mon_cyc.size() < 9 || mon_cyc[3 * k] - t_trig[k] !== 11) begin fails++; $display("FAIL dh_latency%0d: got %0d want 11", k, (mon_cyc.size() >= 9) ? mon_cyc[3 * k] - t_trig[k] : -1); end
        end
        for (int k = 1; k < 3; k++) begin
            tests++; if (mon_cyc.size() < 9 || t_wait[k] - mon_cyc[3 * k - 1] !== 21) begin fails++; $display("FAIL dh_holdoff%0d: got %0d want 21", k, (mon_cyc.size() >= 9) ? t_wait[k] - mon_cyc[3 * k - 1] : -1); end
        end
        tests++; if (bc_q.size() !== 3 || bc_q[0] !== 16'd1 || bc_q[1] !== 16'd2 || bc_q[2] !== 16'd3) begin fails++; $display("FAIL dh_burst_steps: got %0d steps, want 1,2,3", bc_q.size()); end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL dh_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        logic [16:0] exp;
        clear();
        pk_done = 0;
        arm(16'd1, 16'd5000, 32'd0, 32'd0, 32'd0);
        fork
            begin send_trig(16'd100); send_trig(16'd6000); end
            begin send_packet(6, 16'h4000); pk_done = 1; end
            begin
                while (!pk_done) begin
                    m_data_tready = ~m_data_tready;
                    #1;
                    if (sts_state === 3'd3) begin
                        tests++; if (s_data_tready !== m_data_tready) begin fails++; $display("FAIL bp_mirror: got s_tready=%b want %b", s_data_tready, m_data_tready); end
                    end
                    @(posedge aclk); #1;
                end
            end
        join
        m_data_tready = 1'b1;
        tick(); tick();
        tests++; if (mon_q.size() !== 6) begin fails++; $display("FAIL bp_beats: got %0d want 6", mon_q.size()); end
        for (int i = 0; i < 6; i++) begin
            exp = {1'(i == 5), 16'(16'h4000 + i)};
            tests++; if (i >= mon_q.size() || mon_q[i] !== exp) begin fails++; $display("FAIL bp_beat%0d: got %h want %h", i, (i < mon_q.size()) ? mon_q[i] : 17'h0, exp); end
        end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_abort();
        clear();
        arm(16'd4, 16'd5000, 32'd0, 32'd0, 32'd0);
        fork
            begin send_trig(16'd100); send_trig(16'd6000); end
            send_packet(5, 16'h5000);
            begin
                int g;
                g = 0; while (mon_q.size() < 1 && g < 200) begin tick(); g++; end
                cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
            end
        join
        tick(); tick();
        tests++; if (mon_q.size() !== 5 || (mon_q.size() == 5 && mon_q[4] !== {1'b1, 16'h5004})) begin fails++; $display("FAIL abort_full_packet: got %0d beats want 5 ending 15004", mon_q.size()); end
        tests++; if (done_cnt !== 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); end
        tests++; if (sts_burst_cnt !== 16'd1) begin fails++; $display("FAIL abort_burst_cnt: got %0d want 1", sts_burst_cnt); end
        send_trig(16'd100); send_trig(16'd6000);
        tests++; if (sts_state !== 3'd0) begin fails++; $display("FAIL abort_idle: got state %0d want 0", sts_state); end
        cfg_num_bursts = 16'd2; cfg_start = 1'b1; cfg_abort = 1'b1; tick(); cfg_start = 1'b0; cfg_abort = 1'b0;
        tests++; if (sts_state !== 3'd0 || sts_busy !== 1'b0) begin fails++; $display("FAIL start_abort_same: got state %0d busy %b want 0/0", sts_state, sts_busy); end
        tests++; if (sts_burst_cnt !== 16'd1) begin fails++; $display("FAIL start_abort_cnt: got %0d want 1", sts_burst_cnt); end
        arm(16'd2, 16'd5000, 32'd0, 32'd0, 32'd0);
        cfg_abort = 1'b1; tick(); cfg_abort = 1'b0; tick();
        tests++; if (sts_state !== 3'd0 || done_cnt !== 0) begin fails++; $display("FAIL abort_wait: got state %0d done %0d want 0/0", sts_state, done_cnt); end
        arm(16'd0, 16'd5000, 32'd0, 32'd0, 32'd0);
        tests++; if (sts_state !== 3'd0 || sts_done !== 1'b1) begin fails++; $display("FAIL zero_bursts: got state %0d done %b want 0/1", sts_state, sts_done); end
        tick();
        tests++; if (sts_done !== 1'b0) begin fails++; $display("FAIL zero_bursts_pulse: got done %b want 0", sts_done); end
    endtask

    task automatic test_timeout();
        int c0;
        int g;
        clear();
`ifdef AXIS_TRIG_SCHED_TIMEOUT_EN
        arm(16'd1, 16'd5000, 32'd0, 32'd0, 32'd50);
        c0 = cyc;
        g = 0; while (sts_state !== 3'd0 && g < 200) begin tick(); g++; end
        tests++; if (cyc - c0 !== 50) begin fails++; $display("FAIL timeout_cycles: got %0d want 50", cyc - c0); end
        tick();
        tests++; if (sts_timeout !== 1'b1) begin fails++; $display("FAIL timeout_flag: got %b want 1", sts_timeout); end
        tests++; if (done_cnt !== 0) begin fails++; $display("FAIL timeout_no_done: got %0d want 0", done_cnt); end
        arm(16'd1, 16'd5000, 32'd0, 32'd0, 32'd0);
        tests++; if (sts_timeout !== 1'b0 || sts_state !== 3'd1) begin fails++; $display("FAIL timeout_clear: got flag %b state %0d want 0/1", sts_timeout, sts_state); end
`else
        arm(16'd1, 16'd5000, 32'd0, 32'd0, 32'd50);
        c0 = cyc;
        g = 0; while (g < 60) begin tick(); g++; end
        tests++; if (sts_state !== 3'd1 || sts_timeout !== 1'b0) begin fails++; $display("FAIL timeout_disabled: got state %0d flag %b after %0d cycles want 1/0", sts_state, sts_timeout, cyc - c0); end
`endif
        cfg_abort = 1'b1; tick(); cfg_abort = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_level_no_crossing();
        test_delay_holdoff();
        test_backpressure();
        test_abort();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/axis_trigger_burst_sched.md
Name: axis_trigger_burst_sched

Overview:
- Sequencer for the trigger-gated DMA->DAC stream path. Replaces a free-running threshold gate with a software-armed controller.
- On arm, it plays N DMA packets. Each packet starts on its own ADC threshold crossing, after a programmable trigger delay. Consecutive packets are separated by a programmable holdoff.
- Sits between the AXI-Stream DMA MM2S and the DAC, with the ADC stream tapped as the trigger source. It exposes config/status ports to an AXI-Lite register wrapper.

Parameters:
- DATA_WIDTH, 16, DMA/DAC stream width.
- TRIG_DATA_WIDTH, 16, ADC trigger stream width.
- SAMPLE_WIDTH, 16, signed sample width; the trigger compares s_trig_tdata[SAMPLE_WIDTH-1:0].
- CNT_WIDTH, 32, width of the delay, holdoff and timeout counters.
- BURST_WIDTH, 16, width of the burst count.

Ports:
- aclk in 1: the only clock.
- aresetn in 1: synchronous, active-low reset.
- cfg_start in 1: one-cycle arm pulse.
- cfg_abort in 1: one-cycle abort pulse.
- cfg_num_bursts in BURST_WIDTH: number of packets per arm.
- cfg_threshold in SAMPLE_WIDTH: signed trigger level.
- cfg_delay in CNT_WIDTH: cycles from trigger to pass-through.
- cfg_holdoff in CNT_WIDTH: cycles after a packet's TLAST before re-arming.
- cfg_timeout in CNT_WIDTH: WAIT_TRIG timeout (optional feature only).
- s_data_tdata/tvalid/tlast in, s_data_tready out: DMA stream.
- m_data_tdata/tvalid/tlast out, m_data_tready in: DAC stream.
- s_trig_tdata in TRIG_DATA_WIDTH, s_trig_tvalid in 1, s_trig_tready out 1: ADC trigger stream.
- sts_busy out 1: state != IDLE.
- sts_done out 1: one-cycle pulse on normal completion.
- sts_state out 3: encoding IDLE=0, WAIT_TRIG=1, DELAY=2, RUN=3, HOLDOFF=4.
- sts_burst_cnt out BURST_WIDTH: packets completed since the last arm.
- sts_timeout out 1: sticky timeout flag.

Behaviour:
- Reset (aresetn low at a posedge): state=IDLE; all counters=0; sts_done=0; sts_timeout=0; abort_pending=0; prev_valid=0.
- Config latch: cfg_num_bursts, cfg_threshold, cfg_delay, cfg_holdoff and cfg_timeout are latched on an accepted cfg_start. Config changes while busy are ignored.
- s_trig_tready is constant 1; trigger beats are consumed and discarded in every state.
- Data gating:
  - Outside RUN: s_data_tready=0, m_data_tvalid=0, m_data_tdata=0, m_data_tlast=0.
  - In RUN: combinational pass-through with zero latency: m_data_tvalid=s_data_tvalid, m_data_tdata=s_data_tdata, m_data_tlast=s_data_tlast, s_data_tready=m_data_tready.
- Trigger detection is a rising crossing, evaluated only on valid trig beats while in WAIT_TRIG:
  - Fires when prev_valid && prev <= thr && cur > thr (signed compare).
  - prev and prev_valid are updated on every valid beat.
  - prev_valid is cleared on entry to WAIT_TRIG, so the first beat after entry only loads prev and can never fire.
- IDLE:
  - cfg_start with latched num_bursts != 0: burst_cnt=0, go to WAIT_TRIG.
  - cfg_start with num_bursts == 0: pulse sts_done next cycle, stay IDLE.
- WAIT_TRIG:
  - On a crossing, go to DELAY if delay != 0, else go directly to RUN.
  - RUN is entered the cycle after the triggering beat; the first data beat can transfer that cycle.
- DELAY: counter runs from 0 and moves to RUN when count == delay-1. Total trigger-to-RUN latency is delay+1 cycles.
- RUN: on a TLAST handshake (s_data_tvalid && s_data_tready && s_data_tlast), burst_cnt increments, then:
  - if the new count == num_bursts, go to IDLE and pulse sts_done;
  - else if abort_pending, go to IDLE with no done pulse;
  - else go to HOLDOFF if holdoff != 0, else to WAIT_TRIG.
- HOLDOFF: counts holdoff cycles, then goes to WAIT_TRIG. Triggers are ignored during HOLDOFF.
- Abort rules:
  - cfg_abort in WAIT_TRIG, DELAY or HOLDOFF: go to IDLE next cycle, no sts_done.
  - cfg_abort in RUN: sets abort_pending and the packet completes to TLAST; packets are never truncated. abort_pending clears when IDLE is entered.
  - cfg_start and cfg_abort in the same IDLE cycle: abort wins and the block is not armed.
  - cfg_start while busy is ignored.
- sts_burst_cnt holds its final value in IDLE until the next accepted start.
- Counters never wrap. Delay and holdoff are compared for equality, so cfg values up to 2^CNT_WIDTH-1 are legal.

Optional Feature:
- Macro: AXIS_TRIG_SCHED_TIMEOUT_EN.
- Defined:
  - A WAIT_TRIG cycle counter is active. If the latched timeout != 0 and the counter reaches timeout-1 without a trigger, the block goes to IDLE, sets sts_timeout (sticky) and does not pulse sts_done.
  - The counter restarts on each WAIT_TRIG entry.
  - sts_timeout clears on an accepted cfg_start.
- Undefined: cfg_timeout is ignored and sts_timeout is tied to 0.

Test Plan:
- Single burst, zero delay: num=1, thr=5000, delay=0, holdoff=0. Trig sequence 100, 4000, 6000. Response: RUN on the cycle after the 6000 beat; a 4-beat packet passes unchanged; sts_done pulses once; sts_burst_cnt=1.
- Level without crossing: trig held at 6000 from WAIT_TRIG entry -> no trigger fires. After a 100 beat then a 6000 beat -> trigger fires.
- Delay and holdoff: num=3, delay=10, holdoff=20. Response: each packet's first beat appears exactly 11 cycles after its trigger beat; crossings during HOLDOFF are ignored; sts_burst_cnt steps 1, 2, 3; one done pulse.
- DAC backpressure: m_data_tready toggles 1/0 during RUN. Response: no beat is lost or duplicated; tlast is aligned; s_data_tready mirrors m_data_tready.
- Abort mid-packet: cfg_abort on the 2nd beat of a 5-beat packet with num=4. Response: all 5 beats pass, then IDLE, no sts_done, sts_burst_cnt=1. Also: start and abort together in IDLE -> stays IDLE.
- Timeout (macro defined): timeout=50, no crossing. Response: IDLE after 50 WAIT_TRIG cycles, sts_timeout=1; the next cfg_start clears it.
